// File: rtl/multi_channel_mac.sv
`default_nettype none
// ============================================================================
// Module      : multi_channel_mac
// Description : Round-robin bus access controller for NUM_CH requesters with
//               per-request burst length and ack-timeout abort.
// Revision    : 1.0 - initial release
// ============================================================================
module multi_channel_mac #(
    parameter int NUM_CH  = 2,
    parameter int BURST_W = 4,
    parameter int TIMEOUT = 15
) (
    input  logic                      clk,
    input  logic                      reset_n,
    input  logic [NUM_CH-1:0]         mr,
    input  logic [NUM_CH-1:0]         mw,
    input  logic [NUM_CH*BURST_W-1:0] burst_len,
    input  logic                      ack_n,
    output logic [1:0]                sm_state,
    output logic                      as_n,
    output logic                      wr_n,
    output logic                      stop_n,
    output logic [NUM_CH-1:0]         grant,
    output logic [NUM_CH-1:0]         done,
    output logic [NUM_CH-1:0]         err,
    output logic                      in_init,
    output logic                      busy
);

    localparam int              c_PW        = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
    localparam int              c_CW        = $clog2(TIMEOUT);
    localparam logic [c_CW-1:0] c_TO_LAST   = c_CW'(TIMEOUT - 1);
    localparam logic [c_PW-1:0] c_PTR_RST   = c_PW'(NUM_CH - 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'b00,
        S_START = 2'b01,
        S_DATA  = 2'b10,
        S_ABORT = 2'b11
    } state_t;

    state_t               r_state;
    state_t               w_state_nxt;
    logic [c_PW-1:0]      r_ch,   w_ch_nxt;
    logic                 r_op,   w_op_nxt;
    logic [BURST_W-1:0]   r_rem,  w_rem_nxt;
    logic [c_CW-1:0]      r_cnt,  w_cnt_nxt;
    logic [c_PW-1:0]      r_ptr,  w_ptr_nxt;
    logic [NUM_CH-1:0]    r_done, w_done_nxt;

    logic [NUM_CH-1:0]    w_req;
    logic                 w_found;
    logic [c_PW-1:0]      w_sel;
    logic [NUM_CH-1:0]    w_ch_oh;
    logic                 w_active;

    assign w_req   = mr | mw;
    assign w_ch_oh = {{(NUM_CH-1){1'b0}}, 1'b1} << r_ch;

    // Search starts one past the last owner so every requester gets a turn.
    always_comb begin
        w_found = 1'b0;
        w_sel   = r_ptr;
        for (int i = 1; i <= NUM_CH; i++) begin
            if (!w_found && w_req[(int'(r_ptr) + i) % NUM_CH]) begin
                w_found = 1'b1;
                w_sel   = c_PW'((int'(r_ptr) + i) % NUM_CH);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_state <= S_IDLE;
            r_ch    <= '0;
            r_op    <= 1'b0;
            r_rem   <= '0;
            r_cnt   <= '0;
            r_ptr   <= c_PTR_RST;
            r_done  <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_ch    <= w_ch_nxt;
            r_op    <= w_op_nxt;
            r_rem   <= w_rem_nxt;
            r_cnt   <= w_cnt_nxt;
            r_ptr   <= w_ptr_nxt;
            r_done  <= w_done_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_ch_nxt    = r_ch;
        w_op_nxt    = r_op;
        w_rem_nxt   = r_rem;
        w_cnt_nxt   = r_cnt;
        w_ptr_nxt   = r_ptr;
        w_done_nxt  = '0;
        case (r_state)
            S_IDLE: begin
                if (w_found) begin
                    w_ch_nxt    = w_sel;
                    w_op_nxt    = mw[w_sel];
                    w_rem_nxt   = burst_len[w_sel*BURST_W +: BURST_W];
                    w_ptr_nxt   = w_sel;
                    w_state_nxt = S_START;
                end
            end
            S_START: begin
                w_cnt_nxt   = '0;
                w_state_nxt = S_DATA;
            end
            S_DATA: begin
                if (!ack_n) begin
                    if (r_rem == '0) begin
                        w_done_nxt  = w_ch_oh;
                        w_state_nxt = S_IDLE;
                    end else begin
                        w_rem_nxt = r_rem - 1'b1;
                        w_cnt_nxt = '0;
                    end
                end else if (r_cnt == c_TO_LAST) begin
                    w_state_nxt = S_ABORT;
                end else if (r_cnt != '1) begin
                    w_cnt_nxt = r_cnt + 1'b1;
                end
            end
            S_ABORT: begin
                w_state_nxt = S_IDLE;
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    assign w_active = (r_state == S_START) || (r_state == S_DATA);

    assign sm_state = r_state;
    assign as_n     = (r_state != S_START);
    assign in_init  = (r_state == S_START);
    assign busy     = (r_state != S_IDLE);
    assign grant    = w_active ? w_ch_oh : '0;
    assign wr_n     = w_active ? ~r_op : 1'b1;
    assign stop_n   = w_active ? (r_rem != '0) : (r_state != S_ABORT);
    assign done     = r_done;
    assign err      = (r_state == S_ABORT) ? w_ch_oh : '0;

endmodule
`default_nettype wire

// File: tb/tb_multi_channel_mac.sv
`default_nettype none
// ============================================================================
// Module      : tb_multi_channel_mac
// Description : Scoreboard bench for multi_channel_mac with directed bursts.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_multi_channel_mac;

    logic       clk;
    logic       reset_n;
    logic [1:0] mr, mw;
    logic [7:0] burst_len;
    logic       ack_n;
    logic [1:0] sm_state;
    logic       as_n, wr_n, stop_n, in_init, busy;
    logic [1:0] grant, done, err;

    multi_channel_mac #(.NUM_CH(2), .BURST_W(4), .TIMEOUT(15)) u_dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .mr        (mr),
        .mw        (mw),
        .burst_len (burst_len),
        .ack_n     (ack_n),
        .sm_state  (sm_state),
        .as_n      (as_n),
        .wr_n      (wr_n),
        .stop_n    (stop_n),
        .grant     (grant),
        .done      (done),
        .err       (err),
        .in_init   (in_init),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int          n_cmp = 0;
    int          n_bad = 0;
    logic [31:0] exp_q[$];
    logic        mon_en = 1'b0;
    logic [1:0]  prev_sm = 2'b00;
    int          data_cnt = 0;

    // Event records: {kind[3:0], payload[27:0]}
    function automatic logic [31:0] e_start(input logic [1:0] g, input logic w, input logic s);
        return {4'd1, 20'b0, g, w, s, 1'b0, 1'b1, 2'b00};
    endfunction
    function automatic logic [31:0] e_ack(input logic s, input logic [1:0] g);
        return {4'd2, 25'b0, s, g};
    endfunction
    function automatic logic [31:0] e_done(input logic [1:0] d);
        return {4'd3, 20'b0, d, 2'b00, 2'b00, 2'b00};
    endfunction
    function automatic logic [31:0] e_err(input logic [1:0] e, input logic [4:0] cyc);
        return {4'd4, 14'b0, e, 2'b00, 1'b0, 1'b1, 1'b1, 2'b00, cyc};
    endfunction

    always @(negedge clk) begin
        logic [31:0] obs;
        logic        have;
        logic [31:0] expv;
        have = 1'b0;
        obs  = '0;
        case (sm_state)
            2'b01: begin
                have     = 1'b1;
                obs      = {4'd1, 20'b0, grant, wr_n, stop_n, as_n, in_init, prev_sm};
                data_cnt = 0;
            end
            2'b10: begin
                data_cnt++;
                if (!ack_n) begin
                    have = 1'b1;
                    obs  = {4'd2, 25'b0, stop_n, grant};
                end
            end
            2'b11: begin
                have = 1'b1;
                obs  = {4'd4, 14'b0, err, done, stop_n, as_n, wr_n, grant, data_cnt[4:0]};
            end
            default: begin
                if (done != 2'b00 || err != 2'b00) begin
                    have = 1'b1;
                    obs  = {4'd3, 20'b0, done, err, grant, sm_state};
                end
            end
        endcase
        prev_sm = sm_state;
        if (mon_en && have) begin
            n_cmp++;
            if (exp_q.size() == 0) begin
                n_bad++;
                $display("FAIL scoreboard_unexpected kind=%0d got=%h required=none", obs[31:28], obs);
            end else begin
                expv = exp_q.pop_front();
                if (obs !== expv) begin
                    n_bad++;
                    $display("FAIL scoreboard kind=%0d got=%h required=%h", expv[31:28], obs, expv);
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_cmp++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s got=%h required=%h", name, act, req);
        end
    endtask

    task automatic wait_sm(input logic [1:0] s, input int maxc);
        int k;
        k = 0;
        while (sm_state != s && k < maxc) begin
            tick();
            k++;
        end
        check("wait_state", {30'b0, sm_state}, {30'b0, s});
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog got=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        reset_n   = 1'b0;
        mr        = 2'b00;
        mw        = 2'b00;
        burst_len = 8'h00;
        ack_n     = 1'b1;

        // 1: reset
        tick();
        tick();
        check("rst_state",  {30'b0, sm_state}, 32'd0);
        check("rst_strobe", {29'b0, as_n, wr_n, stop_n}, 32'd7);
        check("rst_grant",  {30'b0, grant}, 32'd0);
        check("rst_busy",   {31'b0, busy}, 32'd0);
        reset_n = 1'b1;
        mon_en  = 1'b1;
        tick();

        // 2: single-beat write on ch0
        exp_q.push_back(e_start(2'b01, 1'b0, 1'b0));
        exp_q.push_back(e_ack(1'b0, 2'b01));
        exp_q.push_back(e_done(2'b01));
        mw = 2'b01;
        tick();
        mw = 2'b00;
        check("t2_start_busy_init", {30'b0, busy, in_init}, 32'd3);
        tick();
        check("t2_data_state", {30'b0, sm_state}, 32'd2);
        ack_n = 1'b0;
        tick();
        ack_n = 1'b1;
        check("t2_done", {30'b0, done}, 32'd1);
        tick();

        // 3: 4-beat read on ch1, ack every 2nd DATA cycle
        exp_q.push_back(e_start(2'b10, 1'b1, 1'b1));
        exp_q.push_back(e_ack(1'b1, 2'b10));
        exp_q.push_back(e_ack(1'b1, 2'b10));
        exp_q.push_back(e_ack(1'b1, 2'b10));
        exp_q.push_back(e_ack(1'b0, 2'b10));
        exp_q.push_back(e_done(2'b10));
        mr        = 2'b10;
        burst_len = 8'h30;
        tick();
        mr = 2'b00;
        tick();
        for (int b = 0; b < 4; b++) begin
            ack_n = 1'b1;
            tick();
            ack_n = 1'b0;
            tick();
        end
        ack_n = 1'b1;

        // 4: both channels held, round-robin alternation
        burst_len = 8'h00;
        mr        = 2'b11;
        for (int k = 0; k < 4; k++) begin
            logic [1:0] g;
            g = (k % 2 == 0) ? 2'b01 : 2'b10;
            exp_q.push_back(e_start(g, 1'b1, 1'b0));
            exp_q.push_back(e_ack(1'b0, g));
            exp_q.push_back(e_done(g));
        end
        for (int k = 0; k < 4; k++) begin
            wait_sm(2'b10, 6);
            ack_n = 1'b0;
            if (k == 3) mr = 2'b00;
            tick();
            ack_n = 1'b1;
        end

        // 5: write timeout on ch1
        exp_q.push_back(e_start(2'b10, 1'b0, 1'b1));
        exp_q.push_back(e_err(2'b10, 5'd15));
        mw        = 2'b10;
        burst_len = 8'h20;
        tick();
        mw = 2'b00;
        wait_sm(2'b11, 20);
        check("t5_abort_stop_err", {29'b0, stop_n, err}, 32'h2);
        tick();
        check("t5_idle_nodone", {28'b0, sm_state, done}, 32'd0);
        tick();

        // 6: reset mid-burst restores channel 0 priority
        exp_q.push_back(e_start(2'b01, 1'b1, 1'b1));
        mr        = 2'b01;
        burst_len = 8'h03;
        tick();
        mr = 2'b00;
        tick();
        tick();
        reset_n = 1'b0;
        tick();
        reset_n = 1'b1;
        check("t6_rst_idle", {26'b0, sm_state, grant, done}, 32'd0);
        check("t6_rst_stop", {31'b0, stop_n}, 32'd1);
        exp_q.push_back(e_start(2'b01, 1'b1, 1'b0));
        exp_q.push_back(e_ack(1'b0, 2'b01));
        exp_q.push_back(e_done(2'b01));
        mr        = 2'b11;
        burst_len = 8'h00;
        tick();
        mr = 2'b00;
        check("t6_grant_ch0", {30'b0, grant}, 32'd1);
        tick();
        ack_n = 1'b0;
        tick();
        ack_n = 1'b1;
        repeat (3) tick();

        check("queue_drained", exp_q.size(), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
